// File: rtl/mem_port_arbiter.sv
// Shares one address/data-phase memory bus port between instruction fetch and data access.
// Data requests normally win; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  input  logic              flush,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              if_stall_o,
  output logic              mem_stall_o
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e              state_q, state_d;
  logic                own_q, own_d;
  logic                drop_q, drop_d;
  logic [3:0]          starve_cnt_q, starve_cnt_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_wr_q, bus_wr_d;
  logic [1:0]          bus_size_q, bus_size_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;

  logic grant_data, grant_inst, drop_now;

  // Priority data grant is skipped once the fetch has waited out the limit.
  always_comb begin
    grant_data = data_req && (starve_cnt_q != LIMIT);
    grant_inst = !grant_data && inst_req && !flush;
    if (!grant_data && !grant_inst && data_req)
      grant_data = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    own_d        = own_q;
    drop_d       = drop_q;
    starve_cnt_d = starve_cnt_q;
    bus_req_d    = bus_req_q;
    bus_wr_d     = bus_wr_q;
    bus_size_d   = bus_size_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d     = ADDR;
          own_d       = 1'b1;
          bus_req_d   = 1'b1;
          bus_wr_d    = data_wr;
          bus_size_d  = data_size;
          bus_addr_d  = data_addr;
          bus_wdata_d = data_wdata;
          if (!inst_req)
            starve_cnt_d = 4'd0;
          else if (starve_cnt_q != LIMIT)
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else if (grant_inst) begin
          state_d      = ADDR;
          own_d        = 1'b0;
          bus_req_d    = 1'b1;
          bus_wr_d     = 1'b0;
          bus_size_d   = 2'd2;
          bus_addr_d   = inst_addr;
          bus_wdata_d  = '0;
          starve_cnt_d = 4'd0;
        end
      end
      ADDR: begin
        if (bus_addr_ok) begin
          bus_req_d = 1'b0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bus_data_ok)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A cancelled fetch still finishes on the bus; only its handshakes are hidden.
    if (state_q != IDLE && !own_q && flush)
      drop_d = 1'b1;
    if (state_q == DATA && bus_data_ok)
      drop_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      own_q        <= 1'b0;
      drop_q       <= 1'b0;
      starve_cnt_q <= 4'd0;
      bus_req_q    <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_size_q   <= 2'd0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      own_q        <= own_d;
      drop_q       <= drop_d;
      starve_cnt_q <= starve_cnt_d;
      bus_req_q    <= bus_req_d;
      bus_wr_q     <= bus_wr_d;
      bus_size_q   <= bus_size_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
    end
  end

  assign drop_now     = drop_q || (state_q != IDLE && !own_q && flush);
  assign inst_addr_ok = (state_q == ADDR) && bus_addr_ok && !own_q && !drop_now;
  assign data_addr_ok = (state_q == ADDR) && bus_addr_ok && own_q;
  assign inst_data_ok = (state_q == DATA) && bus_data_ok && !own_q && !drop_now;
  assign data_data_ok = (state_q == DATA) && bus_data_ok && own_q;
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

  assign bus_req   = bus_req_q;
  assign bus_wr    = bus_wr_q;
  assign bus_size  = bus_size_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

  assign if_stall_o  = inst_req && !inst_data_ok && !flush;
  assign mem_stall_o = data_req && !data_data_ok;

endmodule
